// File: rtl/matrix_frame_capture.sv
// matrix_frame_capture
//   Receiving end of the LED-matrix serial link. Synchronizes the driver's
//   shift clock, storage latch clock, serial data, clear, output enable and
//   row select into basysClk, rebuilds each latched COLS-bit row word, and
//   assembles the rows into a full [row][COLS] frame.
// Ports
//   basysClk     system clock, all state on rising edge
//   reset        async active-high, clears all state
//   shcp, stcp   shift / storage-latch clocks from the driver (async)
//   mr           shift-register clear, active-low (async)
//   oe           output enable, active-low (async)
//   ds           serial data (async)
//   rowsOut      row select, polarity set by ROW_ACT_HIGH (async)
//   clearErrors  sync pulse, clears the sticky error flags
//   board        last complete frame, board[r] is row r
//   frameDone    1-cycle pulse when board updates
//   lengthError  sticky: latch seen with bit count != COLS
//   rowError     sticky: latch with oe active and row select not one-hot
module matrix_frame_capture #(
  parameter int ROWS         = 8,
  parameter int COLS         = 24,
  parameter int SYNC_STAGES  = 2,
  parameter bit ROW_ACT_HIGH = 1'b1
) (
  input  logic                       basysClk,
  input  logic                       reset,
  input  logic                       shcp,
  input  logic                       stcp,
  input  logic                       mr,
  input  logic                       oe,
  input  logic                       ds,
  input  logic [ROWS-1:0]            rowsOut,
  input  logic                       clearErrors,
  output logic [ROWS-1:0][COLS-1:0]  board,
  output logic                       frameDone,
  output logic                       lengthError,
  output logic                       rowError
);

  localparam int CW = $clog2(2*COLS);
  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LW = ROWS + 3;
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(2*COLS-1);
  localparam logic [CW-1:0]   CNT_LEN = CW'(COLS);
  localparam logic [ROWS-1:0] ROW_ONE = ROWS'(1);
  localparam logic [IW-1:0]   ROW_LAST = IW'(ROWS-1);

  // Clock-like inputs carry one extra flop so the edge detector can compare
  // the last two synchronized samples; level inputs stop at SYNC_STAGES so
  // they stay aligned with the synchronized clock sample.
  logic [SYNC_STAGES:0][1:0]     clk_sync;   // {stcp, shcp}
  logic [SYNC_STAGES-1:0][LW-1:0] lvl_sync;  // {rowsOut, oe, mr, ds}

  always_ff @(posedge basysClk or posedge reset) begin
    if (reset) begin
      clk_sync <= '0;
      lvl_sync <= '0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-1:0], {stcp, shcp}};
      lvl_sync <= {lvl_sync[SYNC_STAGES-2:0], {rowsOut, oe, mr, ds}};
    end
  end

  logic            shcp_rise, stcp_rise;
  logic            ds_s, mr_s, oe_s;
  logic [ROWS-1:0] rows_s, rows_act;

  assign shcp_rise = clk_sync[SYNC_STAGES-1][0] & ~clk_sync[SYNC_STAGES][0];
  assign stcp_rise = clk_sync[SYNC_STAGES-1][1] & ~clk_sync[SYNC_STAGES][1];
  assign ds_s      = lvl_sync[SYNC_STAGES-1][0];
  assign mr_s      = lvl_sync[SYNC_STAGES-1][1];
  assign oe_s      = lvl_sync[SYNC_STAGES-1][2];
  assign rows_s    = lvl_sync[SYNC_STAGES-1][LW-1:3];
  assign rows_act  = ROW_ACT_HIGH ? rows_s : ~rows_s;

  // Row decode: one-hot check plus index of the active row.
  logic          one_hot;
  logic [IW-1:0] row_idx;

  always_comb begin
    row_idx = '0;
    one_hot = (rows_act != '0) && ((rows_act & (rows_act - ROW_ONE)) == '0);
    for (int i = 0; i < ROWS; i++)
      if (rows_act[i]) row_idx = IW'(i);
  end

  // Shift register and bit counter ('595 style: the latch sees the
  // pre-shift value when both clocks rise together).
  logic [COLS-1:0] shift_reg;
  logic [CW-1:0]   bit_cnt;

  always_ff @(posedge basysClk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (!mr_s) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      if (shcp_rise) shift_reg <= {shift_reg[COLS-2:0], ds_s};
      if (stcp_rise)
        bit_cnt <= shcp_rise ? CNT_ONE : '0;
      else if (shcp_rise && bit_cnt != CNT_MAX)
        bit_cnt <= bit_cnt + CNT_ONE;
    end
  end

  // The storage latch value equals shift_reg at the latch edge, so a
  // commit writes shift_reg straight into the work frame.
  logic commit, bad_row, last_commit, frame_ok, frame_pend;
  logic [ROWS-1:0]           row_seen;
  logic [ROWS-1:0][COLS-1:0] work;

  assign commit      = stcp_rise & ~oe_s & one_hot;
  assign bad_row     = stcp_rise & ~oe_s & ~one_hot;
  assign last_commit = commit && (row_idx == ROW_LAST);
  assign frame_ok    = last_commit && (&row_seen[ROWS-2:0]);

  always_ff @(posedge basysClk or posedge reset) begin
    if (reset) begin
      work        <= '0;
      row_seen    <= '0;
      frame_pend  <= 1'b0;
      board       <= '0;
      frameDone   <= 1'b0;
      lengthError <= 1'b0;
      rowError    <= 1'b0;
    end else begin
      // board loads one cycle after the final commit so it includes that row
      frame_pend <= frame_ok;
      frameDone  <= frame_pend;
      if (frame_pend) board <= work;
      if (commit) begin
        work[row_idx] <= shift_reg;
        // committing the last row always restarts row tracking, complete or not
        if (last_commit) row_seen <= '0;
        else             row_seen[row_idx] <= 1'b1;
      end
      lengthError <= (lengthError & ~clearErrors) | (stcp_rise && bit_cnt != CNT_LEN);
      rowError    <= (rowError & ~clearErrors) | bad_row;
    end
  end

endmodule

// File: tb/tb_matrix_frame_capture.sv
module tb_matrix_frame_capture;
  logic        basysClk = 1'b0;
  logic        reset, shcp, stcp, mr, oe, ds, clearErrors;
  logic [7:0]  rowsOut;
  logic [7:0][23:0] board;
  logic        frameDone, lengthError, rowError;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  int fd0;

  always #5 basysClk = ~basysClk;

  matrix_frame_capture #(.ROWS(8), .COLS(24), .SYNC_STAGES(2), .ROW_ACT_HIGH(1'b1)) dut (
    .basysClk(basysClk), .reset(reset), .shcp(shcp), .stcp(stcp), .mr(mr), .oe(oe),
    .ds(ds), .rowsOut(rowsOut), .clearErrors(clearErrors), .board(board),
    .frameDone(frameDone), .lengthError(lengthError), .rowError(rowError));

  always @(posedge basysClk) if (frameDone === 1'b1) fd_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(negedge basysClk);
  endtask

  task automatic shift_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ds = w[i];
      cyc(3); shcp = 1'b1;
      cyc(3); shcp = 1'b0;
    end
    cyc(1);
  endtask

  task automatic latch(input logic [7:0] rows, input logic oe_v);
    rowsOut = rows; oe = oe_v;
    cyc(3); stcp = 1'b1;
    cyc(3); stcp = 1'b0;
    cyc(4);
    oe = 1'b1; rowsOut = 8'h00;
    cyc(1);
  endtask

  task automatic send_row(input logic [23:0] w, input int r);
    shift_bits({8'h00, w}, 24);
    latch(8'(1 << r), 1'b0);
  endtask

  task automatic clear_errs();
    clearErrors = 1'b1; cyc(1); clearErrors = 1'b0; cyc(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      shcp = i[0]; stcp = i[1]; ds = i[2]; mr = i[0] ^ i[2]; oe = i[1];
      rowsOut = 8'(i * 37);
      cyc(3);
    end
    n_cmp++; if (board !== '0) begin n_bad++; $display("FAIL reset_board: got %h want 0", board); end
    n_cmp++; if (fd_cnt !== 0) begin n_bad++; $display("FAIL reset_framedone: got %0d pulses want 0", fd_cnt); end
    n_cmp++; if ({lengthError, rowError} !== 2'b00) begin n_bad++; $display("FAIL reset_errors: got %b want 00", {lengthError, rowError}); end
    shcp = 0; stcp = 0; ds = 0; mr = 1; oe = 1; rowsOut = 0;
    cyc(5); reset = 1'b0; cyc(10);
    n_cmp++; if (board !== '0 || fd_cnt !== 0) begin n_bad++; $display("FAIL release_idle: board %h pulses %0d want 0/0", board, fd_cnt); end
    n_cmp++; if ({lengthError, rowError} !== 2'b00) begin n_bad++; $display("FAIL release_errors: got %b want 00", {lengthError, rowError}); end
  endtask

  task automatic test_frame();
    fd0 = fd_cnt;
    send_row(24'hA5C3F0, 0);
    for (int r = 1; r < 8; r++) send_row(24'(r), r);
    n_cmp++; if (fd_cnt - fd0 !== 1) begin n_bad++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt - fd0); end
    n_cmp++; if (board[0] !== 24'hA5C3F0) begin n_bad++; $display("FAIL frame_row0: got %h want a5c3f0", board[0]); end
    n_cmp++; if (board[3] !== 24'h000003) begin n_bad++; $display("FAIL frame_row3: got %h want 000003", board[3]); end
    n_cmp++; if (board[7] !== 24'h000007) begin n_bad++; $display("FAIL frame_row7: got %h want 000007", board[7]); end
    n_cmp++; if ({lengthError, rowError} !== 2'b00) begin n_bad++; $display("FAIL frame_errors: got %b want 00", {lengthError, rowError}); end
  endtask

  task automatic test_length();
    shift_bits(32'h0, 23);
    latch(8'h00, 1'b1);
    n_cmp++; if (lengthError !== 1'b1) begin n_bad++; $display("FAIL len_short: got %b want 1", lengthError); end
    clear_errs();
    n_cmp++; if (lengthError !== 1'b0) begin n_bad++; $display("FAIL len_clear: got %b want 0", lengthError); end
    shift_bits(32'h0, 25);
    latch(8'h00, 1'b1);
    n_cmp++; if (lengthError !== 1'b1) begin n_bad++; $display("FAIL len_long: got %b want 1", lengthError); end
    clear_errs();
    send_row(24'h123456, 0);
    n_cmp++; if (lengthError !== 1'b0) begin n_bad++; $display("FAIL len_ok: got %b want 0", lengthError); end
  endtask

  task automatic test_row_error();
    shift_bits(32'h00DEAD00, 24);
    latch(8'h03, 1'b0);
    n_cmp++; if (rowError !== 1'b1) begin n_bad++; $display("FAIL row_multi: got %b want 1", rowError); end
    clear_errs();
    n_cmp++; if (rowError !== 1'b0) begin n_bad++; $display("FAIL row_clear: got %b want 0", rowError); end
    shift_bits(32'h00BEEF00, 24);
    latch(8'h03, 1'b1);
    n_cmp++; if ({lengthError, rowError} !== 2'b00) begin n_bad++; $display("FAIL row_blanked: got %b want 00", {lengthError, rowError}); end
    shift_bits(32'h00BEEF00, 24);
    latch(8'h00, 1'b0);
    n_cmp++; if (rowError !== 1'b1) begin n_bad++; $display("FAIL row_none: got %b want 1", rowError); end
    clear_errs();
  endtask

  task automatic test_partial();
    fd0 = fd_cnt;
    for (int r = 0; r < 4; r++) send_row(24'h0F0000 + 24'(r), r);
    send_row(24'h0F0007, 7);
    n_cmp++; if (fd_cnt - fd0 !== 0) begin n_bad++; $display("FAIL partial_done: got %0d want 0", fd_cnt - fd0); end
    n_cmp++; if (board[0] !== 24'hA5C3F0 || board[7] !== 24'h000007) begin n_bad++; $display("FAIL partial_board: got %h/%h want a5c3f0/000007", board[0], board[7]); end
    for (int r = 0; r < 8; r++) send_row(24'h100000 + 24'(r), r);
    n_cmp++; if (fd_cnt - fd0 !== 1) begin n_bad++; $display("FAIL full_done: got %0d want 1", fd_cnt - fd0); end
    n_cmp++; if (board[0] !== 24'h100000 || board[4] !== 24'h100004 || board[7] !== 24'h100007) begin n_bad++; $display("FAIL full_board: got %h/%h/%h want 100000/100004/100007", board[0], board[4], board[7]); end
    cyc(20);
    n_cmp++; if (board[5] !== 24'h100005) begin n_bad++; $display("FAIL board_hold: got %h want 100005", board[5]); end
  endtask

  task automatic test_mr_and_reset();
    fd0 = fd_cnt;
    shift_bits(32'h3FF, 10);
    mr = 1'b0; cyc(4); mr = 1'b1; cyc(4);
    send_row(24'h5A5A5A, 0);
    n_cmp++; if (lengthError !== 1'b0) begin n_bad++; $display("FAIL mr_len: got %b want 0", lengthError); end
    for (int r = 1; r < 8; r++) send_row(24'h200000 + 24'(r), r);
    n_cmp++; if (fd_cnt - fd0 !== 1) begin n_bad++; $display("FAIL mr_done: got %0d want 1", fd_cnt - fd0); end
    n_cmp++; if (board[0] !== 24'h5A5A5A || board[6] !== 24'h200006) begin n_bad++; $display("FAIL mr_board: got %h/%h want 5a5a5a/200006", board[0], board[6]); end
    fd0 = fd_cnt;
    for (int r = 0; r < 3; r++) send_row(24'h300000 + 24'(r), r);
    reset = 1'b1; cyc(4);
    n_cmp++; if (board !== '0 || {lengthError, rowError} !== 2'b00) begin n_bad++; $display("FAIL midreset: board %h err %b want 0/00", board, {lengthError, rowError}); end
    reset = 1'b0; cyc(6);
    for (int r = 3; r < 8; r++) send_row(24'h300000 + 24'(r), r);
    n_cmp++; if (fd_cnt - fd0 !== 0 || board !== '0) begin n_bad++; $display("FAIL midreset_discard: pulses %0d board %h want 0/0", fd_cnt - fd0, board); end
  endtask

  initial begin
    reset = 1'b1; shcp = 0; stcp = 0; mr = 1; oe = 1; ds = 0; rowsOut = 0; clearErrors = 0;
    test_reset();
    test_frame();
    test_length();
    test_row_error();
    test_partial();
    test_mr_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
